// File: rtl/dot_prod_feeder_if.sv
// dot_prod_feeder_if: element stream, kernel array/control port and result stream of the feeder.
// The master modport is the feeder's view; the slave modport is the host and kernel side.
interface dot_prod_feeder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 27,
  parameter int ACC_W  = 64,
  parameter int CYC_W  = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a;
  logic signed [DATA_W-1:0] in_b;
  logic                     in_last;
  logic                     controlArr;
  logic                     controlArrWEnable_a;
  logic                     controlArrWEnable_b;
  logic [ADDR_W-1:0]        controlArrAddr_a;
  logic [ADDR_W-1:0]        controlArrAddr_b;
  logic signed [DATA_W-1:0] controlArrWData_a;
  logic signed [DATA_W-1:0] controlArrWData_b;
  logic                     r_enable;
  logic [ADDR_W-1:0]        init_i_t_a;
  logic signed [ACC_W-1:0]  init_acc_t_a;
  logic                     w_enable;
  logic signed [ACC_W-1:0]  result;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [ACC_W-1:0]  res_data;
  logic                     res_trunc;
  logic [CYC_W-1:0]         res_cycles;
  modport master (
    input  in_valid, in_a, in_b, in_last, w_enable, result, res_ready,
    output in_ready, controlArr, controlArrWEnable_a, controlArrWEnable_b,
           controlArrAddr_a, controlArrAddr_b, controlArrWData_a, controlArrWData_b,
           r_enable, init_i_t_a, init_acc_t_a, res_valid, res_data, res_trunc, res_cycles
  );
  modport slave (
    output in_valid, in_a, in_b, in_last, w_enable, result, res_ready,
    input  in_ready, controlArr, controlArrWEnable_a, controlArrWEnable_b,
           controlArrAddr_a, controlArrAddr_b, controlArrWData_a, controlArrWData_b,
           r_enable, init_i_t_a, init_acc_t_a, res_valid, res_data, res_trunc, res_cycles
  );
endinterface

// File: rtl/dot_prod_feeder.sv
// dot_prod_feeder: loads (a,b) pairs into the kernel arrays top-down, starts the kernel and returns its result.
module dot_prod_feeder #(
  parameter int DEPTH  = 1000,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 27,
  parameter int ACC_W  = 64,
  parameter int CYC_W  = 16
) (
  input logic              clk,
  input logic              rst_n,
  dot_prod_feeder_if.master bus
);
  typedef enum logic [2:0] {LOAD, FLUSH, KICK, RUN, RESULT} state_t;
  state_t                   state_q;
  logic [ADDR_W-1:0]        count_q, addr_q, init_q;
  logic                     we_q, in_ready_q, ctrl_q, r_en_q, trunc_q, res_valid_q, res_trunc_q;
  logic signed [DATA_W-1:0] wa_q, wb_q;
  logic signed [ACC_W-1:0]  res_q;
  logic [CYC_W-1:0]         cyc_q, cyc_d, res_cyc_q;
  logic                     hs, last;
  assign hs    = bus.in_valid && in_ready_q;
  assign last  = bus.in_last || count_q == ADDR_W'(DEPTH - 1);
  assign cyc_d = cyc_q + CYC_W'(~&cyc_q);
  assign bus.in_ready            = in_ready_q;
  assign bus.controlArr          = ctrl_q;
  assign bus.controlArrWEnable_a = we_q;
  assign bus.controlArrWEnable_b = we_q;
  assign bus.controlArrAddr_a    = addr_q;
  assign bus.controlArrAddr_b    = addr_q;
  assign bus.controlArrWData_a   = wa_q;
  assign bus.controlArrWData_b   = wb_q;
  assign bus.r_enable            = r_en_q;
  assign bus.init_i_t_a          = init_q;
  assign bus.init_acc_t_a        = '0;
  assign bus.res_valid           = res_valid_q;
  assign bus.res_data            = res_q;
  assign bus.res_trunc           = res_trunc_q;
  assign bus.res_cycles          = res_cyc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      count_q     <= '0;
      addr_q      <= '0;
      init_q      <= '0;
      we_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      ctrl_q      <= 1'b0;
      r_en_q      <= 1'b0;
      trunc_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_trunc_q <= 1'b0;
      wa_q        <= '0;
      wb_q        <= '0;
      res_q       <= '0;
      cyc_q       <= '0;
      res_cyc_q   <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          ctrl_q     <= 1'b1;
          we_q       <= hs;
          in_ready_q <= !(hs && last);
          if (hs) begin
            addr_q  <= ADDR_W'(DEPTH - 1) - count_q;
            wa_q    <= bus.in_a;
            wb_q    <= bus.in_b;
            count_q <= count_q + 1'b1;
            if (last) begin
              trunc_q <= !bus.in_last;
              state_q <= FLUSH;
            end
          end
        end
        FLUSH: begin
          we_q    <= 1'b0;
          ctrl_q  <= 1'b0;
          r_en_q  <= 1'b1;
          init_q  <= ADDR_W'(DEPTH) - count_q;
          state_q <= KICK;
        end
        // w_enable still reflects the previous run here, so it is not looked at
        KICK: begin
          r_en_q  <= 1'b0;
          cyc_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          cyc_q <= cyc_d;
          if (bus.w_enable) begin
            res_q       <= bus.result;
            res_trunc_q <= trunc_q;
            res_cyc_q   <= cyc_d;
            res_valid_q <= 1'b1;
            state_q     <= RESULT;
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            ctrl_q      <= 1'b1;
            state_q     <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_prod_feeder.sv
// tb_dot_prod_feeder: directed sequence with a behavioural kernel and write/init/result scoreboards.
module tb_dot_prod_feeder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dot_prod_feeder_if bus ();
  dot_prod_feeder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {int addr; int a; int b;} wr_t;
  typedef struct {longint d; longint t;} res_t;
  wr_t    wq[$];
  res_t   rq[$];
  int     iq[$];
  int     n_chk = 0, n_fail = 0, lat = 0, rpulses = 0;
  longint sum = 0;
  int     n = 0;
  logic signed [26:0] mem_a[1000], mem_b[1000];
  bit     busy = 0, run = 0;
  int     kcnt = 0, kinit = 0, rcyc = 0, meas = 0;
  localparam int M = -(1 << 26);

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int a, input int b, input bit last);
    wq.push_back('{999 - n, a, b});
    sum += longint'(a) * longint'(b);
    n++;
    if (last || n == 1000) begin
      rq.push_back('{sum, longint'(!last)});
      iq.push_back(1000 - n);
      sum = 0;
      n = 0;
    end
  endtask

  task automatic push(input int a, input int b, input bit last);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_a = 27'(a);
    bus.in_b = 27'(b);
    bus.in_last = last;
    while (!bus.in_ready && t < 5000) begin
      step;
      t++;
    end
    if (t >= 5000) check("push_timeout", 0, 1);
    else accept(a, b, last);
    step;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic wait_idle;
    int t = 0;
    while ((rq.size() != 0 || !bus.in_ready) && t < 5000) begin
      step;
      t++;
    end
    check("idle_timeout", longint'(t < 5000), 1);
  endtask

  // kernel model and monitors; kernel updates w_enable before the cycle measurement looks at it
  always @(negedge clk) begin
    wr_t    e;
    res_t   r;
    longint s;
    if (rst_n) begin
      if (bus.controlArrWEnable_a || bus.controlArrWEnable_b) begin
        check("we_pair", bus.controlArrWEnable_a, bus.controlArrWEnable_b);
        check("we_owned", bus.controlArr, 1);
        check("addr_eq", bus.controlArrAddr_a, bus.controlArrAddr_b);
        if (wq.size() == 0) check("extra_write", 1, 0);
        else begin
          e = wq.pop_front();
          check("wr_addr", bus.controlArrAddr_a, e.addr);
          check("wr_a", bus.controlArrWData_a, e.a);
          check("wr_b", bus.controlArrWData_b, e.b);
        end
        if (bus.controlArrAddr_a < 1000) begin
          mem_a[bus.controlArrAddr_a] = bus.controlArrWData_a;
          mem_b[bus.controlArrAddr_a] = bus.controlArrWData_b;
        end
      end
      if (bus.r_enable) begin
        bus.w_enable = 1'b0;
        busy = 1;
        kcnt = lat > 0 ? lat : int'($urandom_range(1, 12));
        kinit = int'(bus.init_i_t_a);
        rpulses++;
        run = 1;
        rcyc = 0;
        check("r_en_no_own", bus.controlArr, 0);
        if (iq.size() == 0) check("extra_kick", 1, 0);
        else check("init_i", bus.init_i_t_a, iq.pop_front());
        check("init_acc", bus.init_acc_t_a, 0);
      end else begin
        if (busy) begin
          kcnt--;
          if (kcnt == 0) begin
            s = 0;
            for (int i = kinit; i < 1000; i++) s += longint'(mem_a[i]) * longint'(mem_b[i]);
            bus.result = s;
            bus.w_enable = 1'b1;
            busy = 0;
          end
        end
        if (run) begin
          rcyc++;
          if (bus.w_enable) begin
            meas = rcyc;
            run = 0;
          end
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        if (rq.size() == 0) check("extra_result", 1, 0);
        else begin
          r = rq.pop_front();
          check("res_data", bus.res_data, r.d);
          check("res_trunc", bus.res_trunc, r.t);
          check("res_cycles", bus.res_cycles, meas);
        end
      end
    end
  end

  initial begin
    longint d;
    int     p0, t;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_last = 1'b0;
    bus.res_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_ctrl", bus.controlArr, 0);
    check("rst_r_en", bus.r_enable, 0);
    check("rst_res_valid", bus.res_valid, 0);
    step;
    step;
    rst_n = 1'b1;
    step;
    check("load_in_ready", bus.in_ready, 1);
    check("load_ctrl", bus.controlArr, 1);
    check("load_we", bus.controlArrWEnable_a, 0);
    // basic
    bus.res_ready = 1'b1;
    push(1, 4, 0);
    push(2, 5, 0);
    push(3, 6, 1);
    wait_idle;
    // signed and extreme operands
    push(-5, 7, 1);
    wait_idle;
    push(M, M, 0);
    push(M, M, 1);
    wait_idle;
    // throttled input, then result back-pressure
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(3, 3, i == 3);
      step;
    end
    t = 0;
    while (!bus.res_valid && t < 200) begin
      step;
      t++;
    end
    check("res_valid_timeout", longint'(t < 200), 1);
    d = bus.res_data;
    check("hold_data", d, 36);
    for (int i = 0; i < 10; i++) begin
      step;
      check("hold_valid", bus.res_valid, 1);
      check("hold_data", bus.res_data, d);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.res_ready = 1'b1;
    wait_idle;
    // truncation at DEPTH; the extra pair starts the next vector
    for (int i = 0; i < 1001; i++) push(1, 1, 0);
    push(2, 3, 1);
    wait_idle;
    // reset while the kernel is running
    lat = 30;
    push(5, 5, 0);
    push(5, 5, 1);
    t = 0;
    while (!bus.r_enable && t < 100) begin
      step;
      t++;
    end
    check("kick_timeout", longint'(t < 100), 1);
    step;
    step;
    step;
    #2 rst_n = 1'b0;
    #1;
    check("mid_in_ready", bus.in_ready, 0);
    check("mid_ctrl", bus.controlArr, 0);
    check("mid_r_en", bus.r_enable, 0);
    check("mid_init_i", bus.init_i_t_a, 0);
    check("mid_addr", bus.controlArrAddr_a, 0);
    check("mid_wdata", bus.controlArrWData_a, 0);
    check("mid_res_data", bus.res_data, 0);
    check("mid_res_valid", bus.res_valid, 0);
    rq.delete();
    iq.delete();
    wq.delete();
    sum = 0;
    n = 0;
    step;
    rst_n = 1'b1;
    step;
    check("post_rst_ready", bus.in_ready, 1);
    lat = 0;
    push(1, 2, 0);
    push(1, 2, 1);
    wait_idle;
    // back-to-back vectors
    p0 = rpulses;
    push(1, 1, 0);
    push(2, 2, 1);
    push(3, 3, 0);
    push(4, 4, 1);
    wait_idle;
    check("kick_pulses", rpulses - p0, 2);
    check("wq_empty", wq.size(), 0);
    check("iq_empty", iq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dot_prod_feeder.md
Name: dot_prod_feeder

Overview:
- Upstream host-side sequencer for the synthesized dot-product kernel.
- Accepts a valid/ready stream of signed (a,b) element pairs and writes them into the kernel's arr_a/arr_b memories through the kernel's controlArr port pair.
- Starts the kernel with r_enable, waits for its w_enable, and returns the 64-bit result on a valid/ready output with a cycle count.

Parameters:
DEPTH, 1000, kernel loop end index; max elements per vector
ADDR_W, 10, array address width
DATA_W, 27, signed element width
ACC_W, 64, signed accumulator/result width
CYC_W, 16, cycle-counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  element pair valid
in_ready  out  1  feeder accepts element
in_a  in  DATA_W  signed element of vector a
in_b  in  DATA_W  signed element of vector b
in_last  in  1  final element of vector
controlArr  out  1  feeder owns kernel arrays
controlArrWEnable_a / controlArrWEnable_b  out  1  array write enables
controlArrAddr_a / controlArrAddr_b  out  ADDR_W  array addresses (always equal)
controlArrWData_a / controlArrWData_b  out  DATA_W  array write data
r_enable  out  1  kernel start/init pulse
init_i_t_a  out  ADDR_W  kernel start index
init_acc_t_a  out  ACC_W  kernel initial accumulator, tied 0
w_enable  in  1  kernel done (level)
result  in  ACC_W  kernel result, valid while w_enable=1
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  ACC_W  signed dot product
res_trunc  out  1  vector truncated at DEPTH elements
res_cycles  out  CYC_W  kernel cycles, r_enable to w_enable, saturating

Behaviour:
- Reset (async assert, sync release): state=LOAD, count=0, all outputs 0, except in_ready=1 once in LOAD after release.
- Kernel sums indices init_i..DEPTH-1. Element k (0-based) is written to address DEPTH-1-k (reverse order; sum is order-invariant). After N elements, init_i_t_a = DEPTH-N.
- LOAD: in_ready=1, controlArr=1.
  - On handshake, register WEnable_a/b=1, Addr=DEPTH-1-count, WData=in_a/in_b for exactly one cycle (write presented the cycle after handshake). Increment count.
  - Handshake with in_last=1, or count==DEPTH-1 (forced last; trunc=in_last==0) -> FLUSH.
- FLUSH: in_ready=0, controlArr=1, the final write is presented. Latch init_i_t_a=DEPTH-count -> KICK.
- KICK (1 cycle): controlArr=0, WEnable=0, r_enable=1, cycle counter cleared -> RUN.
  - w_enable is ignored in KICK, since its value is stale until the kernel samples r_enable.
- RUN: r_enable=0, controlArr=0, counter increments (saturates at all-ones).
  - On w_enable=1: capture result into res_data, and set res_trunc and res_cycles -> RESULT.
- RESULT: res_valid=1, data stable until res_valid&&res_ready. On that handshake: res_valid=0, count=0 -> LOAD (in_ready=1 next cycle).
- in_ready is 0 in FLUSH/KICK/RUN/RESULT; no element is accepted while a vector is in flight.
- Write enables are never 1 when controlArr=0. Address/data hold their last value when idle.
- Reset mid-operation: everything returns to reset values immediately. The kernel is not restarted until the next vector completes loading.
- res_data is passed through unmodified (kernel's 64-bit wrap arithmetic).

Test Plan:
- Basic: N=3, a={1,2,3}, b={4,5,6}, in_last on 3rd -> writes at addr 999,998,997; init_i_t_a=997; one r_enable pulse; res_data=32, res_trunc=0.
- Signed: N=1, a={-5}, b={7} -> addr 999, init_i_t_a=999, res_data=-35. Then N=2, a={-2^26,-2^26}, b={-2^26,-2^26} -> res_data=2^53.
- Throttling: in_valid toggled every other cycle with N=4 all a=b=3 -> 4 writes only on handshake cycles, res_data=36. Hold res_ready=0 10 cycles -> res_valid, res_data stay stable; in_ready stays 0.
- Truncation: 1001 pairs a=b=1, in_last never set -> 1000 accepted, init_i_t_a=0, res_data=1000, res_trunc=1. Pair 1001 is accepted as element 0 of the next vector after the result handshake.
- Reset mid-RUN: assert rst_n=0 while kernel busy -> outputs 0 asynchronously. After release, a fresh N=2 vector {1,1}·{2,2} -> res_data=4.
- Back-to-back: two vectors each consumed with res_ready=1 -> exactly two r_enable pulses. res_cycles equals the monitored r_enable-to-w_enable distance.
